ex_muldiv_seq: RTL
==================

Name: ex_muldiv_seq

Overview:
- Sequencer for an iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the EX stage.
- Accepts one M-extension operation from the ID/EX operands and stalls the front of the pipeline while it iterates.
- Presents a one-cycle-valid result that the EX/MEM register captures in place of the ALU result.
- Handles the RISC-V divide-by-zero and signed-overflow cases without iterating, and supports abort on flush.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous reset, active-high.
- start_i  input  1  EX holds a valid M-extension instruction.
- op_i  input  3  funct3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- rs1_i  input  XLEN  operand A (forwarded rs1).
- rs2_i  input  XLEN  operand B (forwarded rs2).
- flush_i  input  1  abort the current operation (branch/exception flush).
- result_o  output  XLEN  final result; meaningful only while valid_o=1.
- valid_o  output  1  result ready this cycle.
- busy_o  output  1  FSM not in IDLE.
- stall_o  output  1  hold PC, IF/ID and ID/EX registers this cycle.

Behaviour:
- Reset: one clock and synchronous active-high reset (rst_i); reset is sampled on the clk_i rising edge.
  - Reset forces state=IDLE.
  - Outputs after reset: result_o=0, valid_o=0, busy_o=0, stall_o=0.
  - Counter and operand registers are cleared to 0.
  - Reset mid-operation abandons the operation silently; valid_o is never asserted for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start_i=1 and flush_i=0 at cycle N: latch op, |rs1|, |rs2|, the sign-fixup flags and the raw operands; cnt=0.
  - Divide by zero (op 4-7, rs2=0): go to DONE at N+1.
  - Signed overflow (op DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go to DONE at N+1.
  - Otherwise go to BUSY at N+1.
  - stall_o is combinational: (state==IDLE & start_i & ~flush_i) | state==BUSY.
- BUSY:
  - One radix-2 step per cycle; cnt increments.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring division of magnitudes.
  - After XLEN steps (cnt==XLEN-1 at the clock edge), go to DONE.
  - For a normal op, BUSY occupies cycles N+1 to N+XLEN; DONE is at N+XLEN+1.
- DONE:
  - valid_o=1 and stall_o=0 for exactly one cycle, so the pipeline advances and captures result_o.
  - Next state is unconditionally IDLE.
  - start_i in DONE belongs to the retiring instruction and is ignored.
  - Back-to-back M ops are therefore accepted no earlier than the cycle after DONE.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH: high XLEN bits, signed x signed.
  - MULHSU: high XLEN bits, signed rs1 x unsigned rs2.
  - MULHU: high XLEN bits, unsigned x unsigned.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Sign fixup, applied at the DONE transition:
  - Product is negated if the operand signs differ (signed operands only).
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
- Special cases:
  - Divide by zero: quotient = all ones, remainder = rs1.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Flush:
  - flush_i in BUSY or DONE returns to IDLE next cycle, with valid_o=0 from that cycle.
  - In the DONE cycle itself, valid_o=1 is still driven; the pipeline's flush logic discards it.
  - flush_i with start_i in IDLE: the operation is not accepted.
- Simultaneous rst_i and flush_i: reset wins.
- busy_o = (state != IDLE).

Decomposition:
- Shared package (muldiv_pkg):
  - funct3 op encodings as localparams.
  - State enum {IDLE, BUSY, DONE}.
  - Helper predicates is_div(op) and is_signed_a(op)/is_signed_b(op).
- One sub-module, muldiv_core:
  - Holds the accumulator/remainder registers and a step/init/fixup datapath.
  - Controlled by ex_muldiv_seq through init, step and finish strobes.
- ex_muldiv_seq owns the FSM, counter, special-case detection and the stall/valid outputs.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> stall_o high cycles 0-32; valid_o only at cycle 33; result_o=0xFFFFFFEB.
- MULHU rs1=rs2=0xFFFFFFFF -> result_o=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result_o=0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU rs2=0, rs1=0x1234 -> valid_o at cycle 2, result_o=0xFFFFFFFF; REMU same -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 2; REM -> 0.
- flush_i at cycle 10 of a DIV -> busy_o=0 at cycle 11; valid_o never asserted; a new MUL started at cycle 12 completes with the correct result.
- rst_i at cycle 5 of a MUL -> all outputs 0 from the next cycle; no valid_o; start_i held high in DONE does not launch a second operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and op predicates for the M-extension unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Remainder ops return the partial remainder rather than the quotient.
  function automatic logic is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM.
  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - EX-stage request/result bundle between pipeline and mul/div sequencer
interface ex_muldiv_seq_if #(
  parameter int XLEN = 32
);

  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic            busy_o;
  logic            stall_o;

  // Pipeline side: issues operations, consumes result and stall.
  modport master (
    output start_i, op_i, rs1_i, rs2_i, flush_i,
    input  result_o, valid_o, busy_o, stall_o
  );

  // Unit side.
  modport slave (
    input  start_i, op_i, rs1_i, rs2_i, flush_i,
    output result_o, valid_o, busy_o, stall_o
  );

endinterface

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - radix-2 shift-add multiply / restoring divide datapath with sign fixup
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  input  logic            step_i,
  input  logic            finish_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            div_zero_i,
  input  logic            ovf_i,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]      op_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [XLEN-1:0] hi_q;   // product high half / partial remainder
  logic [XLEN-1:0] lo_q;   // multiplier then product low half / dividend then quotient
  logic [XLEN-1:0] b_q;    // |rs2|: multiplicand or divisor
  logic [XLEN-1:0] res_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   add;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] nxt_hi;
  logic [XLEN-1:0] nxt_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] fixed;

  assign a_neg = is_signed_a(op_i) & rs1_i[XLEN-1];
  assign b_neg = is_signed_b(op_i) & rs2_i[XLEN-1];
  assign a_mag = a_neg ? (~rs1_i + 1'b1) : rs1_i;
  assign b_mag = b_neg ? (~rs2_i + 1'b1) : rs2_i;

  // One iteration of the shared step: add-and-shift-right for multiply, trial subtract for divide.
  always_comb begin
    add     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    nxt_hi  = hi_q;
    nxt_lo  = lo_q;
    if (is_div(op_q)) begin
      // No borrow means the divisor fits: keep the difference and shift in a 1.
      nxt_hi = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      nxt_lo = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      nxt_hi = add[XLEN:1];
      nxt_lo = {add[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fixup on the values the final step produces, so the result is ready in DONE.
  always_comb begin
    prod  = {nxt_hi, nxt_lo};
    if (a_neg_q ^ b_neg_q) prod = ~prod + 1'b1;
    quot  = (a_neg_q ^ b_neg_q) ? (~nxt_lo + 1'b1) : nxt_lo;
    rem   = a_neg_q ? (~nxt_hi + 1'b1) : nxt_hi;
    fixed = '0;
    if (is_div(op_q))       fixed = op_q[1] ? rem : quot;
    else if (op_q == OP_MUL) fixed = prod[XLEN-1:0];
    else                    fixed = prod[2*XLEN-1:XLEN];
  end

  // Operand capture on init, iteration on step, result register on finish or special case.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else if (init_i) begin
      op_q    <= op_i;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      hi_q    <= '0;
      lo_q    <= a_mag;
      b_q     <= b_mag;
      if (div_zero_i)
        res_q <= is_rem(op_i) ? rs1_i : '1;
      else if (ovf_i)
        res_q <= is_rem(op_i) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (step_i) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
      if (finish_i) res_q <= fixed;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - EX-stage sequencer for iterative RV32M multiply/divide with stall and flush
module ex_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ex_muldiv_seq_if.slave bus
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;

  logic accept;
  logic div_zero;
  logic ovf;
  logic special;
  logic step;
  logic last;

  assign accept   = (state_q == IDLE) & bus.start_i & ~bus.flush_i;
  assign div_zero = is_div(bus.op_i) & (bus.rs2_i == '0);
  assign ovf      = ((bus.op_i == OP_DIV) || (bus.op_i == OP_REM)) &
                    (bus.rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.rs2_i == '1);
  assign special  = div_zero | ovf;
  assign step     = (state_q == BUSY) & ~bus.flush_i;
  assign last     = step & (cnt_q == CNT_W'(XLEN-1));

  // Sequencer FSM: accept in IDLE, iterate XLEN steps in BUSY, present result for one cycle in DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (accept) begin
            cnt_q <= '0;
            if (special) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (last) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  muldiv_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .init_i     (accept),
    .step_i     (step),
    .finish_i   (last),
    .op_i       (bus.op_i),
    .rs1_i      (bus.rs1_i),
    .rs2_i      (bus.rs2_i),
    .div_zero_i (div_zero),
    .ovf_i      (ovf),
    .result_o   (bus.result_o)
  );

  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.stall_o = accept | (state_q == BUSY);

endmodule
